// File: rtl/approx_mw_add_ctrl.sv
// rtl/approx_mw_add_ctrl.sv - byte-serial approximate adder sequencer (optional error monitor: APPROX_ERRMON_EN)
// One shared 8-bit approximate slice is walked LSB byte first, carrying through a register between cycles.
module approx_mw_add_ctrl #(
  parameter int WORDS = 4,
  parameter int CW    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*WORDS-1:0]   op_a,
  input  logic [8*WORDS-1:0]   op_b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*WORDS-1:0]   sum,
  output logic                 cout,
  output logic                 busy
`ifdef APPROX_ERRMON_EN
  ,
  output logic                 err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  state_t               r_state;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 r_busy;
  logic [8*WORDS-1:0]   r_a;
  logic [8*WORDS-1:0]   r_b;
  logic [8*WORDS-1:0]   r_sum;
  logic                 r_cout;
  logic                 r_carry;
  logic [CW-1:0]        r_cnt;

  logic [7:0]           w_a_byte;
  logic [7:0]           w_b_byte;
  logic [8:0]           w_slice;

  // Sum bit is OR-ed with the incoming carry instead of XOR-ed; carry logic is exact.
  function automatic logic [8:0] f_approx_slice(input logic [7:0] a, input logic [7:0] b,
                                                input logic c);
    logic [7:0] s;
    logic       k;
    k = c;
    for (int i = 0; i < 8; i++) begin
      s[i] = (a[i] ^ b[i]) | k;
      k    = (a[i] & b[i]) | ((a[i] ^ b[i]) & k);
    end
    return {k, s};
  endfunction

  assign w_a_byte = r_a[8*r_cnt +: 8];
  assign w_b_byte = r_b[8*r_cnt +: 8];
  assign w_slice  = f_approx_slice(w_a_byte, w_b_byte, r_carry);

`ifdef APPROX_ERRMON_EN
  logic       r_ecarry;
  logic       r_err;
  logic [8:0] w_exact;
  logic       w_byte_diff;

  assign w_exact     = {1'b0, w_a_byte} + {1'b0, w_b_byte} + {8'd0, r_ecarry};
  // Bytewise mismatch plus a final carry mismatch is equivalent to comparing {cout,sum} whole.
  assign w_byte_diff = (w_slice[7:0] != w_exact[7:0]) ||
                       ((r_cnt == LAST) && (w_slice[8] != w_exact[8]));
  assign err         = r_err;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
`ifdef APPROX_ERRMON_EN
      r_ecarry    <= 1'b0;
      r_err       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_in_ready && in_valid) begin
            r_a        <= op_a;
            r_b        <= op_b;
            r_carry    <= cin;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_RUN;
`ifdef APPROX_ERRMON_EN
            r_ecarry   <= cin;
            r_err      <= 1'b0;
`endif
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        S_RUN: begin
          r_sum[8*r_cnt +: 8] <= w_slice[7:0];
          r_carry             <= w_slice[8];
          r_cnt               <= r_cnt + CW'(1);
`ifdef APPROX_ERRMON_EN
          r_ecarry            <= w_exact[8];
          r_err               <= r_err | w_byte_diff;
`endif
          if (r_cnt == LAST) begin
            r_cout      <= w_slice[8];
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

// File: tb/tb_approx_mw_add_ctrl.sv
// tb/tb_approx_mw_add_ctrl.sv - directed self-checking bench for approx_mw_add_ctrl
// Hand-computed vectors; outputs sampled on the falling edge.
module tb_approx_mw_add_ctrl;

  localparam int WORDS = 4;
  localparam int CW    = 4;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [8*WORDS-1:0]   op_a;
  logic [8*WORDS-1:0]   op_b;
  logic                 cin;
  logic                 out_valid;
  logic                 out_ready;
  logic [8*WORDS-1:0]   sum;
  logic                 cout;
  logic                 busy;
`ifdef APPROX_ERRMON_EN
  logic                 err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  approx_mw_add_ctrl #(.WORDS(WORDS), .CW(CW)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef APPROX_ERRMON_EN
    ,
    .err       (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Accept one operation and wait (bounded) for out_valid; leaves the DUT in HOLD.
  task automatic start_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic c);
    int lat;
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    cin      = c;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
    cin      = 1'b1;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_in_ready_run"}, in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, WORDS);
  endtask

  task automatic check_result(input string tag, input logic [31:0] exp_sum, input logic exp_cout,
                              input logic exp_err);
    check({tag, "_sum"}, sum, exp_sum);
    check({tag, "_cout"}, cout, exp_cout);
    check({tag, "_busy_hold"}, busy, 0);
`ifdef APPROX_ERRMON_EN
    check({tag, "_err"}, err, exp_err);
`else
    if (exp_err === 1'bx) $display("unused");
`endif
  endtask

  task automatic release_op(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, out_valid, 0);
    check({tag, "_in_ready_back"}, in_ready, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    cin       = 1'b0;
    out_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    start_op("basic", 32'h0000_0001, 32'h0000_0001, 1'b0);
    check_result("basic", 32'h0000_0002, 1'b0, 1'b0);
    release_op("basic");

    start_op("xslice", 32'h0000_0080, 32'h0000_0080, 1'b0);
    check_result("xslice", 32'h0000_0100, 1'b0, 1'b0);
    release_op("xslice");

    start_op("approx", 32'h0000_00FF, 32'h0000_0001, 1'b0);
    check_result("approx", 32'h0000_01FE, 1'b0, 1'b1);
    release_op("approx");

    start_op("chain", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    check_result("chain", 32'hFFFF_FFFF, 1'b1, 1'b1);
    release_op("chain");

    // Backpressure: result must hold and new requests must be ignored.
    start_op("bp", 32'h1234_5678, 32'h0101_0101, 1'b0);
    check_result("bp", 32'h1335_5779, 1'b0, 1'b0);
    in_valid = 1'b1;
    op_a     = 32'hDEAD_BEEF;
    op_b     = 32'h0BAD_F00D;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_sum_stable", sum, 32'h1335_5779);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    release_op("bp");

    // Reset sampled on the second RUN edge discards the operation.
    start_op_abort();
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_in_ready_back", in_ready, 1);
    for (int i = 0; i < WORDS + 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("abort_no_out_valid", out_valid, 0);
    end

    start_op("after", 32'h0000_0010, 32'h0000_0020, 1'b0);
    check_result("after", 32'h0000_0030, 1'b0, 1'b0);
    release_op("after");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  task automatic start_op_abort();
    @(negedge clk);
    check("abort_in_ready", in_ready, 1);
    in_valid = 1'b1;
    op_a     = 32'h0F0F_0F0F;
    op_b     = 32'h0101_0101;
    cin      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready_rst", in_ready, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    @(posedge clk);
    @(negedge clk);
  endtask

endmodule
